// File: rtl/adc_patgen_pkg.sv
// Shared types, PRBS constants and the PRBS-15 step function for the ADC test-pattern source.
package adc_patgen_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    RAMP  = 2'd1,
    PRBS  = 2'd2,
    RSVD  = 2'd3
  } adc_patgen_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } adc_patgen_state_e;

  localparam logic [14:0] PRBS_SEED = 15'h7FFF;
  // x^15 + x^14 + 1 in right-shift form: feedback is bit0 ^ bit1, shifted in at bit 14.
  localparam logic [14:0] PRBS_TAPS = 15'h0003;

  function automatic logic [14:0] prbs_next(input logic [14:0] s);
    return {^(s & PRBS_TAPS), s[14:1]};
  endfunction

endpackage

// File: rtl/adc_patgen_lfsr.sv
// PRBS-15 state register: reloads the seed on load, takes one step on advance.
module adc_patgen_lfsr
  import adc_patgen_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_i,
  input  logic        advance_i,
  output logic [14:0] state_o
);

  logic [14:0] state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= PRBS_SEED;
    end else if (load_i) begin
      state_q <= PRBS_SEED;
    end else if (advance_i) begin
      state_q <= prbs_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/adc_pattern_gen.sv
// Multi-channel synthetic ADC sample source (fixed / ramp / PRBS bursts).
// PRBS generation is built only when ADC_PATGEN_PRBS_EN is defined; otherwise mode 2 yields base 0.
module adc_pattern_gen
  import adc_patgen_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int NUM_CH = 1,
  parameter int CNT_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cfg_en,
  input  logic [1:0]               cfg_mode,
  input  logic [DATA_W-1:0]        cfg_fixed,
  input  logic [DATA_W-1:0]        cfg_step,
  input  logic [GAP_W-1:0]         cfg_gap,
  input  logic [CNT_W-1:0]         cfg_burst_len,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH*DATA_W-1:0] adc_data,
  output logic                     adc_valid,
  output logic [1:0]               dbg_state
);

  // adc_valid is a pure strobe with no backpressure: each high cycle carries exactly one
  // new sample on adc_data, and adc_data holds its last value while adc_valid is low.

  adc_patgen_state_e         state_q;
  adc_patgen_mode_e          mode_q;
  logic [DATA_W-1:0]         fixed_q, step_q, ramp_q, ramp_d;
  logic [GAP_W-1:0]          gap_q, gap_cnt_q;
  logic [CNT_W-1:0]          len_q, cnt_q, cnt_d;
  logic [NUM_CH*DATA_W-1:0]  data_q, data_d;
  logic                      valid_q, busy_q, done_q;

  logic                      accept, last_sample, emit_next;
  logic [DATA_W-1:0]         start_base, run_base;
  logic [DATA_W-1:0]         prbs_seed_base, prbs_run_base;

  function automatic logic [NUM_CH*DATA_W-1:0] fan_out(input logic [DATA_W-1:0] base);
    logic [NUM_CH*DATA_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      r[c*DATA_W +: DATA_W] = base + DATA_W'(c);
    end
    return r;
  endfunction

  assign accept      = (state_q == IDLE) && start && cfg_en;
  assign last_sample = (len_q != '0) && (cnt_q == len_q);
  assign emit_next   = cfg_en &&
                       (((state_q == RUN) && !last_sample && (gap_q == '0)) ||
                        ((state_q == GAP) && (gap_cnt_q == GAP_W'(1))));

`ifdef ADC_PATGEN_PRBS_EN
  logic [14:0] lfsr_state;

  adc_patgen_lfsr u_lfsr (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (accept),
    .advance_i (emit_next && (mode_q == PRBS)),
    .state_o   (lfsr_state)
  );

  // The register holds the value already emitted, so later samples use its successor.
  assign prbs_seed_base = DATA_W'(PRBS_SEED);
  assign prbs_run_base  = DATA_W'(prbs_next(lfsr_state));
`else
  assign prbs_seed_base = '0;
  assign prbs_run_base  = '0;
`endif

  always_comb begin
    start_base = cfg_fixed;
    if (adc_patgen_mode_e'(cfg_mode) == PRBS) begin
      start_base = prbs_seed_base;
    end
    case (mode_q)
      RAMP:    run_base = ramp_q;
      PRBS:    run_base = prbs_run_base;
      default: run_base = fixed_q;
    endcase
    data_d = fan_out(accept ? start_base : run_base);
    ramp_d = accept ? (cfg_fixed + cfg_step) : (ramp_q + step_q);
    cnt_d  = accept ? CNT_W'(1) : (cnt_q + CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      mode_q    <= FIXED;
      fixed_q   <= '0;
      step_q    <= '0;
      gap_q     <= '0;
      len_q     <= '0;
      gap_cnt_q <= '0;
      cnt_q     <= '0;
      ramp_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            mode_q  <= adc_patgen_mode_e'(cfg_mode);
            fixed_q <= cfg_fixed;
            step_q  <= cfg_step;
            gap_q   <= cfg_gap;
            len_q   <= cfg_burst_len;
          end
        end
        RUN: begin
          if (!cfg_en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (last_sample) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_q != '0) begin
            state_q   <= GAP;
            gap_cnt_q <= gap_q;
          end
        end
        GAP: begin
          if (!cfg_en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (gap_cnt_q == GAP_W'(1)) begin
            state_q <= RUN;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (accept || emit_next) begin
        valid_q <= 1'b1;
        data_q  <= data_d;
        cnt_q   <= cnt_d;
        ramp_q  <= ramp_d;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign adc_data  = data_q;
  assign adc_valid = valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Directed + randomized bench for adc_pattern_gen with a cycle-timeline reference model.
module tb_adc_pattern_gen;
  import adc_patgen_pkg::*;

  localparam int DW = 18;
  localparam int NC = 2;
  localparam int CW = 16;
  localparam int GW = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cfg_en = 1'b0;
  logic [1:0]       cfg_mode = '0;
  logic [DW-1:0]    cfg_fixed = '0;
  logic [DW-1:0]    cfg_step = '0;
  logic [GW-1:0]    cfg_gap = '0;
  logic [CW-1:0]    cfg_burst_len = '0;
  logic             start = 1'b0;
  logic             busy, done, adc_valid;
  logic [NC*DW-1:0] adc_data;
  logic [1:0]       dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [NC*DW-1:0] exp_q[$];
  logic [NC*DW-1:0] last_data = '0;

  adc_pattern_gen #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cfg_en        (cfg_en),
    .cfg_mode      (cfg_mode),
    .cfg_fixed     (cfg_fixed),
    .cfg_step      (cfg_step),
    .cfg_gap       (cfg_gap),
    .cfg_burst_len (cfg_burst_len),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PRBS-15 (x^15 + x^14 + 1) sequence value n steps after the 7FFF seed.
  function automatic logic [14:0] prbs_model(input int n);
    logic [14:0] s;
    s = 15'h7FFF;
    for (int i = 0; i < n; i++) s = {s[0] ^ s[1], s[14:1]};
    return s;
  endfunction

  function automatic logic [NC*DW-1:0] model_sample(input int mode, input logic [DW-1:0] fixed,
                                                    input logic [DW-1:0] step, input int n);
    longint b;
    logic [63:0] bv;
    logic [DW-1:0] base;
    logic [NC*DW-1:0] r;
    case (mode)
      1: b = longint'(fixed) + longint'(n) * longint'(step);
`ifdef ADC_PATGEN_PRBS_EN
      2: b = longint'(prbs_model(n));
`else
      2: b = 0;
`endif
      default: b = longint'(fixed);
    endcase
    bv = 64'(b);
    base = bv[DW-1:0];
    for (int c = 0; c < NC; c++) r[c*DW +: DW] = base + DW'(c);
    return r;
  endfunction

  task automatic run_burst(input string tag, input int mode, input logic [DW-1:0] fixed,
                           input logic [DW-1:0] step, input int gap, input int len);
    int last_v, done_c, total;
    logic exp_v;
    logic [NC*DW-1:0] e;
    cfg_mode = 2'(mode);
    cfg_fixed = fixed;
    cfg_step = step;
    cfg_gap = GW'(gap);
    cfg_burst_len = CW'(len);
    for (int k = 0; k < len; k++) exp_q.push_back(model_sample(mode, fixed, step, k));
    last_v = 1 + (len - 1) * (gap + 1);
    done_c = last_v + 1;
    total = done_c + 1;
    start = 1'b1;
    for (int cyc = 1; cyc <= total; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_v = (cyc <= last_v) && (((cyc - 1) % (gap + 1)) == 0);
      check({tag, "_valid"}, 64'(adc_valid), 64'(exp_v));
      if (exp_v && exp_q.size() > 0) last_data = exp_q.pop_front();
      check({tag, "_data"}, 64'(adc_data), 64'(last_data));
      check({tag, "_busy"}, 64'(busy), 64'(cyc <= last_v));
      check({tag, "_done"}, 64'(done), 64'(cyc == done_c));
      if (cyc == 2 && cyc <= last_v) begin
        // start while busy and cfg changes mid-burst must both be ignored
        start = 1'b1;
        cfg_fixed = DW'($urandom);
        cfg_step = DW'($urandom);
        cfg_gap = GW'($urandom_range(0, 5));
        cfg_burst_len = CW'($urandom_range(1, 9));
        cfg_mode = 2'($urandom_range(0, 3));
      end
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_idle"}, 64'(dbg_state), 64'(IDLE));
    exp_q.delete();
  endtask

  initial begin
    // reset
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(adc_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_data", 64'(adc_data), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rstn = 1'b1;
    cfg_en = 1'b1;
    @(posedge clk);
    #1;

    // directed bursts
    run_burst("fixed", 0, DW'(3), DW'(0), 0, 4);
    run_burst("ramp_wrap", 1, DW'('h3FFFE), DW'(1), 0, 3);
    run_burst("gap", 0, DW'('h1234), DW'(0), 2, 3);
    run_burst("prbs", 2, DW'('h0AAA), DW'(7), 0, 3);
    run_burst("prbs_gap", 2, DW'('h0001), DW'(0), 1, 5);
    run_burst("rsvd", 3, DW'('h2BCDE), DW'(9), 1, 2);
    run_burst("single", 1, DW'('h00010), DW'(4), 3, 1);

    // continuous burst aborted by cfg_en
    cfg_mode = 2'd1;
    cfg_fixed = DW'('h100);
    cfg_step = DW'(5);
    cfg_gap = '0;
    cfg_burst_len = '0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == 2);
      last_data = model_sample(1, DW'('h100), DW'(5), cyc - 1);
      if (cyc == 2) cfg_fixed = DW'('h3000);
      check("cont_valid", 64'(adc_valid), 64'(1));
      check("cont_data", 64'(adc_data), 64'(last_data));
      check("cont_busy", 64'(busy), 64'(1));
    end
    cfg_en = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk);
      #1;
      check("abort_valid", 64'(adc_valid), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_state", 64'(dbg_state), 64'(IDLE));
      check("abort_hold", 64'(adc_data), 64'(last_data));
    end

    // start with cfg_en low is ignored
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("dis_valid", 64'(adc_valid), 64'(0));
    check("dis_busy", 64'(busy), 64'(0));
    cfg_en = 1'b1;

    // randomized bursts
    for (int i = 0; i < 10; i++) begin
      run_burst("rand", int'($urandom_range(0, 3)), DW'($urandom), DW'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
    end

    // asynchronous reset while in GAP
    cfg_mode = 2'd0;
    cfg_fixed = DW'('h55);
    cfg_gap = GW'(3);
    cfg_burst_len = CW'(4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("pre_rst_valid", 64'(adc_valid), 64'(1));
    @(posedge clk);
    #1;
    check("pre_rst_state", 64'(dbg_state), 64'(GAP));
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid", 64'(adc_valid), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_data", 64'(adc_data), 64'(0));
    check("arst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    last_data = '0;
    @(posedge clk);
    #1;
    run_burst("post_rst_prbs", 2, DW'(0), DW'(0), 0, 2);
    run_burst("post_rst", 0, DW'(3), DW'(0), 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
